// File: rtl/plab4_net_router_output_ctrl_pkg.sv
// Shared router constants and small helpers for the output-port controller.
package plab4_net_router_output_ctrl_pkg;

    // Port indices of the ring router
    localparam int unsigned c_port_p0   = 0;
    localparam int unsigned c_port_term = 1;
    localparam int unsigned c_port_p2   = 2;
    localparam int unsigned c_num_ports = 3;
    localparam int unsigned c_sel_w     = 2;

    // Output-channel lock state: open for arbitration, or held on a stalled winner
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    // Arbiter result bundle
    typedef struct packed {
        logic [c_num_ports-1:0] grant;
        logic [c_sel_w-1:0]     idx;
        logic                   vld;
    } arb_result_t;

    // Index to one-hot over the three ports
    function automatic logic [c_num_ports-1:0] onehot3(input logic [c_sel_w-1:0] idx);
        logic [c_num_ports-1:0] oh;
        oh = '0;
        case (idx)
            c_sel_w'(c_port_p0):   oh = 3'b001;
            c_sel_w'(c_port_term): oh = 3'b010;
            c_sel_w'(c_port_p2):   oh = 3'b100;
            default:               oh = 3'b001;
        endcase
        return oh;
    endfunction

    // Next port index, wrapping modulo three
    function automatic logic [c_sel_w-1:0] next_idx3(input logic [c_sel_w-1:0] idx);
        return (idx >= c_sel_w'(c_num_ports - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/plab4_net_rr_arb3.sv
// Three-way circular priority scan: first requester at or after the one-hot priority wins.
module plab4_net_rr_arb3
    import plab4_net_router_output_ctrl_pkg::*;
(
    input  logic [2:0] reqs,
    input  logic [2:0] prio,
    output logic [2:0] grant,
    output logic [1:0] idx,
    output logic       vld
);

    arb_result_t res;
    logic [1:0]  start;

    // Starting index of the scan from the one-hot priority
    always_comb begin
        start = 2'd0;
        if (prio[1]) begin
            start = 2'd1;
        end else if (prio[2]) begin
            start = 2'd2;
        end
    end

    // Scan prio, prio+1, prio+2 (mod 3) and take the first requester
    always_comb begin : p_scan
        logic [2:0] pos;
        logic [1:0] cand;
        res = '0;
        for (int unsigned k = 0; k < c_num_ports; k++) begin
            pos = 3'(start) + 3'(k);
            if (pos >= 3'(c_num_ports)) begin
                pos = pos - 3'(c_num_ports);
            end
            cand = pos[1:0];
            if (!res.vld && reqs[cand]) begin
                res.vld   = 1'b1;
                res.idx   = cand;
                res.grant = onehot3(cand);
            end
        end
    end

    assign grant = res.grant;
    assign idx   = res.idx;
    assign vld   = res.vld;

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// Output-port controller: round-robin arbitration over three inputs, lock on downstream stall.
module plab4_net_router_output_ctrl
    import plab4_net_router_output_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       domain,
    input  logic [2:0] reqs,
    output logic [2:0] grants,
    output logic [1:0] sel,
    output logic       out_val,
    input  logic       out_rdy
);

    // Security label only; carries no logic
    logic unused_domain;
    assign unused_domain = domain;

    lock_state_e state_q, state_d;
    logic [2:0]  prio_q, prio_d;
    logic [1:0]  lock_sel_q, lock_sel_d;

    logic [2:0]  arb_grant;
    logic [1:0]  arb_idx;
    logic        arb_vld;

    logic [2:0]  win_oh;
    logic [1:0]  win_idx;
    logic        win_vld;

    plab4_net_rr_arb3 u_arb (
        .reqs  (reqs),
        .prio  (prio_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .vld   (arb_vld)
    );

    // Winner mux: a locked channel keeps its stalled input, otherwise take the arbiter result
    always_comb begin
        win_oh  = arb_grant;
        win_idx = arb_idx;
        win_vld = arb_vld;
        if (state_q == ST_LOCKED) begin
            win_idx = lock_sel_q;
            win_vld = reqs[lock_sel_q];
            win_oh  = win_vld ? onehot3(lock_sel_q) : 3'b000;
        end
    end

    // Zero-latency outputs, forced idle while reset is asserted
    always_comb begin
        grants  = 3'b000;
        sel     = 2'd0;
        out_val = 1'b0;
        if (reset && win_vld) begin
            out_val = 1'b1;
            sel     = win_idx;
            grants  = out_rdy ? win_oh : 3'b000;
        end
    end

    // Next state: transfer rotates priority, stall locks the winner, idle unlocks
    always_comb begin
        state_d    = ST_OPEN;
        prio_d     = prio_q;
        lock_sel_d = lock_sel_q;
        if (win_vld) begin
            if (out_rdy) begin
                prio_d = onehot3(next_idx3(win_idx));
            end else begin
                state_d    = ST_LOCKED;
                lock_sel_d = win_idx;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_OPEN;
            prio_q     <= 3'b001;
            lock_sel_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_sel_q <= lock_sel_d;
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Directed bench for the router output controller with an expected-value scoreboard.
module tb_plab4_net_router_output_ctrl;

    logic       clk;
    logic       reset;
    logic       domain;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic [1:0] sel;
    logic       out_val;
    logic       out_rdy;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_viol = 0;

    typedef struct {
        string      tag;
        logic [2:0] g;
        logic [1:0] s;
        logic       v;
    } exp_t;

    exp_t sb_q[$];

    plab4_net_router_output_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .domain  (domain),
        .reqs    (reqs),
        .grants  (grants),
        .sel     (sel),
        .out_val (out_val),
        .out_rdy (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor and per-cycle grant invariants
    logic       prev_stall = 1'b0;
    logic [1:0] prev_sel   = 2'd0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !reqs[prev_sel]) begin
                n_viol++;
                $display("note: protocol violation, request of locked input %0d dropped", prev_sel);
            end
            n_cmp++;
            assert (($countones(grants) <= 1) && (out_rdy || grants == 3'b000)) else begin
                n_fail++;
                $error("FAIL grant_invariant got grants=%b out_rdy=%b exp onehot0 and gated", grants, out_rdy);
            end
            prev_stall = out_val && !out_rdy;
            prev_sel   = sel;
        end
    end

    task automatic push_exp(input string tag, input logic [2:0] g, input logic [1:0] s, input logic v);
        exp_t e;
        e.tag = tag;
        e.g   = g;
        e.s   = s;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        @(negedge clk);
        n_cmp++;
        assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty got size 0 exp >0");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            assert (grants === e.g) else begin
                n_fail++;
                $error("FAIL %s grants got %b exp %b", e.tag, grants, e.g);
            end
            n_cmp++;
            assert (sel === e.s) else begin
                n_fail++;
                $error("FAIL %s sel got %0d exp %0d", e.tag, sel, e.s);
            end
            n_cmp++;
            assert (out_val === e.v) else begin
                n_fail++;
                $error("FAIL %s out_val got %b exp %b", e.tag, out_val, e.v);
            end
        end
    endtask

    task automatic step(input logic [2:0] r, input logic rdy, input logic [2:0] g,
                        input logic [1:0] s, input logic v, input string tag);
        @(posedge clk);
        #1;
        reqs    = r;
        out_rdy = rdy;
        push_exp(tag, g, s, v);
        check_out();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        reqs    = 3'b000;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b0;
        domain  = 1'b0;
        reqs    = 3'b000;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);

        // Reset masks everything even with requests and ready
        step(3'b111, 1'b1, 3'b000, 2'd0, 1'b0, "reset_mask");

        // T1: release reset, single request from terminal
        @(posedge clk);
        #1;
        reset   = 1'b1;
        reqs    = 3'b010;
        out_rdy = 1'b1;
        push_exp("t1_term", 3'b010, 2'd1, 1'b1);
        check_out();
        step(3'b111, 1'b1, 3'b100, 2'd2, 1'b1, "t1_prio_next");

        // T2: all requesting, rotation from reset
        do_reset();
        step(3'b111, 1'b1, 3'b001, 2'd0, 1'b1, "t2_rr0");
        step(3'b111, 1'b1, 3'b010, 2'd1, 1'b1, "t2_rr1");
        step(3'b111, 1'b1, 3'b100, 2'd2, 1'b1, "t2_rr2");
        step(3'b111, 1'b1, 3'b001, 2'd0, 1'b1, "t2_rr3");

        // T5: idle cycles keep prio (now 010)
        step(3'b000, 1'b0, 3'b000, 2'd0, 1'b0, "t5_idle0");
        step(3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "t5_idle1");
        step(3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "t5_idle2");
        step(3'b111, 1'b1, 3'b010, 2'd1, 1'b1, "t5_prio_kept");

        // T3: stall locks input 0, later request ignored, then transfer and rotate
        do_reset();
        step(3'b001, 1'b0, 3'b000, 2'd0, 1'b1, "t3_stall0");
        step(3'b001, 1'b0, 3'b000, 2'd0, 1'b1, "t3_stall1");
        step(3'b101, 1'b0, 3'b000, 2'd0, 1'b1, "t3_locked");
        step(3'b101, 1'b1, 3'b001, 2'd0, 1'b1, "t3_xfer");
        step(3'b101, 1'b1, 3'b100, 2'd2, 1'b1, "t3_next");

        // T4: lock on input 2, reset mid-cycle drops outputs at once
        do_reset();
        step(3'b100, 1'b0, 3'b000, 2'd2, 1'b1, "t4_stall2");
        @(posedge clk);
        #1;
        reset   = 1'b0;
        out_rdy = 1'b1;
        push_exp("t4_mid_reset", 3'b000, 2'd0, 1'b0);
        check_out();
        @(posedge clk);
        #1;
        reset = 1'b1;
        reqs  = 3'b011;
        push_exp("t4_after_release", 3'b001, 2'd0, 1'b1);
        check_out();
        step(3'b011, 1'b1, 3'b010, 2'd1, 1'b1, "t4_rotate");

        // T6: locked on 2, request drops (protocol violation)
        do_reset();
        step(3'b100, 1'b0, 3'b000, 2'd2, 1'b1, "t6_stall2");
        step(3'b110, 1'b0, 3'b000, 2'd2, 1'b1, "t6_locked_ignore");
        step(3'b001, 1'b1, 3'b000, 2'd0, 1'b0, "t6_drop");
        step(3'b001, 1'b1, 3'b001, 2'd0, 1'b1, "t6_recover");

        n_cmp++;
        assert (n_viol == 1) else begin
            n_fail++;
            $error("FAIL t6_violation_count got %0d exp 1", n_viol);
        end

        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover got %0d exp 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
